// File: rtl/uart_cmd_system_top_if.sv
// ----------------------------------------------------------------------------
// uart_cmd_system_top_if
// Serial-side bundle of the UART command subsystem.
//   serial_data_in   RX line into the subsystem, idle high
//   serial_data_out  TX line out of the subsystem, idle high
//   parity_error     one-cycle pulse on a received frame with bad parity
//   frame_error      one-cycle pulse on a received frame with stop bit 0
// master: the remote UART end (drives the RX line, observes the rest)
// slave : the subsystem itself
// ----------------------------------------------------------------------------
interface uart_cmd_system_top_if;
   logic serial_data_in;
   logic serial_data_out;
   logic parity_error;
   logic frame_error;

   modport master (
      output serial_data_in,
      input  serial_data_out,
      input  parity_error,
      input  frame_error
   );

   modport slave (
      input  serial_data_in,
      output serial_data_out,
      output parity_error,
      output frame_error
   );
endinterface

// File: rtl/uart_cmd_system_top.sv
// ----------------------------------------------------------------------------
// uart_cmd_system_top
// UART-controlled register file / ALU. Command frames arrive on the RX line,
// a controller executes register writes, reads and ALU operations, and the
// results leave as UART frames (start, data LSB first, even parity, stop).
//   reference_clk  system clock, rising edge
//   reset          asynchronous, active high
//   uart_if        serial_data_in / serial_data_out / parity_error / frame_error
//
// Controller states:
//   state     | meaning
//   IDLE      | waiting for a command byte (AA/BB/CC/DD), others ignored
//   WR_ADDR   | write: waiting for the address byte
//   WR_DATA   | write: waiting for the data byte, stored on arrival
//   RD_ADDR   | read: waiting for the address byte
//   ALU_A     | ALU: operand A, stored into reg0
//   ALU_B     | ALU: operand B, stored into reg1
//   ALU_FUNC  | ALU: waiting for the function byte
//   NOP_FUNC  | ALU on current reg0/reg1: waiting for the function byte
//   EXEC      | result computed, low byte handed to the transmitter
//   TX_LO     | low byte on the line, then one idle bit time
//   TX_HI     | high byte on the line
//   TX_RD     | read data on the line
// ----------------------------------------------------------------------------
module uart_cmd_system_top #(
   parameter int DATA_WIDTH          = 8,
   parameter int REGISTER_FILE_DEPTH = 16,
   parameter int PRESCALE            = 8
) (
   input  logic                 reference_clk,
   input  logic                 reset,
   uart_cmd_system_top_if.slave uart_if
);

   localparam int ADDR_W = $clog2(REGISTER_FILE_DEPTH);
   localparam int RES_W  = 2 * DATA_WIDTH;
   localparam int TMR_W  = $clog2(PRESCALE);
   localparam int IDX_W  = $clog2(DATA_WIDTH);

   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(PRESCALE - 1);
   localparam logic [TMR_W-1:0] TMR_FIRST = TMR_W'(PRESCALE - 2);
   localparam logic [TMR_W-1:0] TAP_EARLY = TMR_W'(PRESCALE / 2);
   localparam logic [TMR_W-1:0] TAP_MID   = TMR_W'(PRESCALE / 2 - 1);
   localparam logic [TMR_W-1:0] TAP_VOTE  = TMR_W'(PRESCALE / 2 - 2);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

   localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'('hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'('hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'('hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_NOP = DATA_WIDTH'('hDD);
   localparam logic [DATA_WIDTH-1:0] ZERO_B  = '0;

   // ------------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------------
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

   rx_state_t             rx_state_q, rx_state_d;
   logic                  rx_meta_q, rx_sync_q, rx_prev_q;
   logic [TMR_W-1:0]      rx_tmr_q, rx_tmr_d;
   logic [IDX_W-1:0]      rx_idx_q, rx_idx_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [1:0]            rx_smp_q, rx_smp_d;
   logic                  rx_par_q, rx_par_d;
   logic                  rx_fall, rx_sample, rx_vote_tap, rx_vote;
   logic                  rx_valid, rx_parity_err, rx_frame_err;

   // Two-flop synchronizer; the extra flop gives the falling-edge detector.
   always_ff @(posedge reference_clk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= uart_if.serial_data_in;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   // The bit timer free-runs modulo PRESCALE from the start edge, so each
   // bit's vote lands at the same offset; the state advances at the vote.
   assign rx_fall     = rx_prev_q & ~rx_sync_q;
   assign rx_sample   = (rx_tmr_q == TAP_EARLY) || (rx_tmr_q == TAP_MID);
   assign rx_vote_tap = (rx_tmr_q == TAP_VOTE);
   assign rx_vote     = (rx_smp_q[1] & rx_smp_q[0]) | (rx_smp_q[1] & rx_sync_q) |
                        (rx_smp_q[0] & rx_sync_q);

   always_ff @(posedge reference_clk or posedge reset) begin
      if (reset) begin
         rx_state_q <= RX_IDLE;
         rx_tmr_q   <= '0;
         rx_idx_q   <= '0;
         rx_shift_q <= '0;
         rx_smp_q   <= '0;
         rx_par_q   <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_tmr_q   <= rx_tmr_d;
         rx_idx_q   <= rx_idx_d;
         rx_shift_q <= rx_shift_d;
         rx_smp_q   <= rx_smp_d;
         rx_par_q   <= rx_par_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_tmr_d   = rx_tmr_q;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      rx_smp_d   = rx_smp_q;
      rx_par_d   = rx_par_q;
      if (rx_state_q == RX_IDLE) begin
         if (rx_fall) begin
            rx_state_d = RX_START;
            rx_tmr_d   = TMR_FIRST;   // the edge cycle itself is bit cycle 0
         end
      end else begin
         rx_tmr_d = (rx_tmr_q == '0) ? TMR_LAST : rx_tmr_q - 1'b1;
         if (rx_sample) begin
            rx_smp_d = {rx_smp_q[0], rx_sync_q};
         end
         if (rx_vote_tap) begin
            unique case (rx_state_q)
               RX_START: begin
                  if (rx_vote) begin
                     rx_state_d = RX_IDLE;
                  end else begin
                     rx_state_d = RX_DATA;
                     rx_idx_d   = '0;
                  end
               end
               RX_DATA: begin
                  rx_shift_d = {rx_vote, rx_shift_q[DATA_WIDTH-1:1]};
                  if (rx_idx_q == IDX_LAST) begin
                     rx_state_d = RX_PARITY;
                  end else begin
                     rx_idx_d = rx_idx_q + 1'b1;
                  end
               end
               RX_PARITY: begin
                  rx_par_d   = rx_vote;
                  rx_state_d = RX_STOP;
               end
               default: rx_state_d = RX_IDLE;
            endcase
         end
      end
   end

   // Returning to IDLE at the stop-bit vote lets a start bit that follows
   // the stop bit immediately be caught.
   always_comb begin
      rx_valid      = 1'b0;
      rx_parity_err = 1'b0;
      rx_frame_err  = 1'b0;
      if (rx_state_q == RX_STOP && rx_vote_tap) begin
         rx_parity_err = (^rx_shift_q) != rx_par_q;
         rx_frame_err  = ~rx_vote;
         rx_valid      = ((^rx_shift_q) == rx_par_q) & rx_vote;
      end
   end

   assign uart_if.parity_error = rx_parity_err;
   assign uart_if.frame_error  = rx_frame_err;

   // ------------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------------
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

   tx_state_t             tx_state_q, tx_state_d;
   logic [TMR_W-1:0]      tx_tmr_q, tx_tmr_d;
   logic [IDX_W-1:0]      tx_idx_q, tx_idx_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic                  tx_par_q, tx_par_d;
   logic                  tx_start;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_busy, tx_done, tx_line;

   always_ff @(posedge reference_clk or posedge reset) begin
      if (reset) begin
         tx_state_q <= TX_IDLE;
         tx_tmr_q   <= '0;
         tx_idx_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_tmr_q   <= tx_tmr_d;
         tx_idx_q   <= tx_idx_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_tmr_d   = tx_tmr_q;
      tx_idx_d   = tx_idx_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      if (tx_state_q == TX_IDLE) begin
         if (tx_start) begin
            tx_state_d = TX_START;
            tx_tmr_d   = TMR_LAST;
            tx_idx_d   = '0;
            tx_shift_d = tx_data;
            tx_par_d   = ^tx_data;
         end
      end else if (tx_tmr_q != '0) begin
         tx_tmr_d = tx_tmr_q - 1'b1;
      end else begin
         tx_tmr_d = TMR_LAST;
         unique case (tx_state_q)
            TX_START: tx_state_d = TX_DATA;
            TX_DATA: begin
               tx_shift_d = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
               if (tx_idx_q == IDX_LAST) begin
                  tx_state_d = TX_PARITY;
               end else begin
                  tx_idx_d = tx_idx_q + 1'b1;
               end
            end
            TX_PARITY: tx_state_d = TX_STOP;
            default:   tx_state_d = TX_IDLE;
         endcase
      end
   end

   // The line is decoded from registered state only, so reset drives it
   // high at once.
   always_comb begin
      tx_busy = (tx_state_q != TX_IDLE);
      tx_done = (tx_state_q == TX_STOP) && (tx_tmr_q == '0);
      unique case (tx_state_q)
         TX_START:  tx_line = 1'b0;
         TX_DATA:   tx_line = tx_shift_q[0];
         TX_PARITY: tx_line = tx_par_q;
         default:   tx_line = 1'b1;
      endcase
   end

   assign uart_if.serial_data_out = tx_line;

   // ------------------------------------------------------------------------
   // Register file and ALU
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] rf_q [REGISTER_FILE_DEPTH];
   logic                  rf_we;
   logic [ADDR_W-1:0]     rf_waddr;
   logic [DATA_WIDTH-1:0] rf_wdata;
   logic [DATA_WIDTH-1:0] alu_a, alu_b;
   logic [RES_W-1:0]      alu_res;
   logic [3:0]            func_q, func_d;

   always_ff @(posedge reference_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REGISTER_FILE_DEPTH; i++) begin
            rf_q[i] <= '0;
         end
      end else if (rf_we) begin
         rf_q[rf_waddr] <= rf_wdata;
      end
   end

   assign alu_a = rf_q[0];
   assign alu_b = rf_q[1];

   always_comb begin
      unique case (func_q)
         4'd0:    alu_res = RES_W'(alu_a) + RES_W'(alu_b);
         4'd1:    alu_res = RES_W'(alu_a) - RES_W'(alu_b);
         4'd2:    alu_res = RES_W'(alu_a) * RES_W'(alu_b);
         4'd3:    alu_res = (alu_b == '0) ? '0 : {ZERO_B, alu_a / alu_b};
         4'd4:    alu_res = {ZERO_B, alu_a & alu_b};
         4'd5:    alu_res = {ZERO_B, alu_a | alu_b};
         4'd6:    alu_res = {ZERO_B, ~(alu_a & alu_b)};
         4'd7:    alu_res = {ZERO_B, ~(alu_a | alu_b)};
         4'd8:    alu_res = {ZERO_B, alu_a ^ alu_b};
         4'd9:    alu_res = {ZERO_B, ~(alu_a ^ alu_b)};
         4'd10:   alu_res = (alu_a == alu_b) ? RES_W'(1) : '0;
         4'd11:   alu_res = (alu_a > alu_b) ? RES_W'(2) : '0;
         4'd12:   alu_res = (alu_a < alu_b) ? RES_W'(3) : '0;
         4'd13:   alu_res = {ZERO_B, alu_a >> 1};
         4'd14:   alu_res = RES_W'(alu_a) << 1;
         default: alu_res = '0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Command controller
   // ------------------------------------------------------------------------
   typedef enum logic [3:0] {
      C_IDLE, C_WR_ADDR, C_WR_DATA, C_RD_ADDR, C_ALU_A, C_ALU_B,
      C_ALU_FUNC, C_NOP_FUNC, C_EXEC, C_TX_LO, C_TX_HI, C_TX_RD
   } ctl_state_t;

   ctl_state_t         ctl_state_q, ctl_state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [RES_W-1:0]   result_q, result_d;
   logic [TMR_W-1:0]   gap_tmr_q, gap_tmr_d;
   logic               rd_sent_q, rd_sent_d;

   always_ff @(posedge reference_clk or posedge reset) begin
      if (reset) begin
         ctl_state_q <= C_IDLE;
         addr_q      <= '0;
         func_q      <= '0;
         result_q    <= '0;
         gap_tmr_q   <= '0;
         rd_sent_q   <= 1'b0;
      end else begin
         ctl_state_q <= ctl_state_d;
         addr_q      <= addr_d;
         func_q      <= func_d;
         result_q    <= result_d;
         gap_tmr_q   <= gap_tmr_d;
         rd_sent_q   <= rd_sent_d;
      end
   end

   // States not listed here ignore rx_valid, which drops bytes that arrive
   // while a response is on the line.
   always_comb begin
      ctl_state_d = ctl_state_q;
      addr_d      = addr_q;
      func_d      = func_q;
      result_d    = result_q;
      gap_tmr_d   = gap_tmr_q;
      rd_sent_d   = rd_sent_q;
      unique case (ctl_state_q)
         C_IDLE: begin
            if (rx_valid) begin
               if (rx_shift_q == CMD_WR)       ctl_state_d = C_WR_ADDR;
               else if (rx_shift_q == CMD_RD)  ctl_state_d = C_RD_ADDR;
               else if (rx_shift_q == CMD_ALU) ctl_state_d = C_ALU_A;
               else if (rx_shift_q == CMD_NOP) ctl_state_d = C_NOP_FUNC;
            end
         end
         C_WR_ADDR: begin
            if (rx_valid) begin
               addr_d      = rx_shift_q[ADDR_W-1:0];
               ctl_state_d = C_WR_DATA;
            end
         end
         C_WR_DATA: if (rx_valid) ctl_state_d = C_IDLE;
         C_RD_ADDR: begin
            if (rx_valid) begin
               addr_d      = rx_shift_q[ADDR_W-1:0];
               rd_sent_d   = 1'b0;
               ctl_state_d = C_TX_RD;
            end
         end
         C_ALU_A: if (rx_valid) ctl_state_d = C_ALU_B;
         C_ALU_B: if (rx_valid) ctl_state_d = C_ALU_FUNC;
         C_ALU_FUNC, C_NOP_FUNC: begin
            if (rx_valid) begin
               func_d      = rx_shift_q[3:0];
               ctl_state_d = C_EXEC;
            end
         end
         C_EXEC: begin
            result_d    = alu_res;
            ctl_state_d = C_TX_LO;
         end
         C_TX_LO: begin
            // After the low frame's stop bit, hold the line idle for one bit
            // time; the high byte is launched as the gap timer expires.
            if (tx_done) begin
               gap_tmr_d = TMR_LAST;
            end else if (!tx_busy) begin
               if (gap_tmr_q == '0) ctl_state_d = C_TX_HI;
               else                 gap_tmr_d = gap_tmr_q - 1'b1;
            end
         end
         C_TX_HI: if (tx_done) ctl_state_d = C_IDLE;
         C_TX_RD: begin
            rd_sent_d = 1'b1;
            if (tx_done) ctl_state_d = C_IDLE;
         end
         default: ctl_state_d = C_IDLE;
      endcase
   end

   // EXEC hands the freshly computed low byte straight to the transmitter so
   // its start bit follows the function byte by two cycles, same as a read.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = addr_q;
      rf_wdata = rx_shift_q;
      tx_start = 1'b0;
      tx_data  = result_q[DATA_WIDTH-1:0];
      unique case (ctl_state_q)
         C_WR_DATA: rf_we = rx_valid;
         C_ALU_A: begin
            rf_we    = rx_valid;
            rf_waddr = '0;
         end
         C_ALU_B: begin
            rf_we    = rx_valid;
            rf_waddr = ADDR_W'(1);
         end
         C_EXEC: begin
            tx_start = 1'b1;
            tx_data  = alu_res[DATA_WIDTH-1:0];
         end
         C_TX_LO: begin
            tx_start = !tx_busy && (gap_tmr_q == '0);
            tx_data  = result_q[RES_W-1:DATA_WIDTH];
         end
         C_TX_RD: begin
            tx_start = ~rd_sent_q;
            tx_data  = rf_q[addr_q];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_uart_cmd_system_top.sv
module tb_uart_cmd_system_top;
   localparam int P = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_cmd_system_top_if bus();

   uart_cmd_system_top #(
      .DATA_WIDTH(8), .REGISTER_FILE_DEPTH(16), .PRESCALE(P)
   ) dut (
      .reference_clk(clk),
      .reset(rst),
      .uart_if(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int pe_cnt = 0;
   int fe_cnt = 0;

   logic [7:0] mreg [16];
   logic [7:0] exp_q [$];
   logic [7:0] mon_byte [$];
   logic       mon_par [$];
   logic       mon_stop [$];
   int         mon_t [$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.parity_error === 1'b1) pe_cnt++;
      if (bus.frame_error === 1'b1) fe_cnt++;
   end

   // Frame decoder on the TX line: sample at mid-bit.
   logic [7:0] md;
   logic       mp, ms;
   int         mt;
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && bus.serial_data_out === 1'b0) begin
            mt = cyc;
            repeat (P / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (P) @(negedge clk);
               md[i] = bus.serial_data_out;
            end
            repeat (P) @(negedge clk);
            mp = bus.serial_data_out;
            repeat (P) @(negedge clk);
            ms = bus.serial_data_out;
            mon_byte.push_back(md);
            mon_par.push_back(mp);
            mon_stop.push_back(ms);
            mon_t.push_back(mt);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop);
      bus.serial_data_in = 1'b0;
      repeat (P) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.serial_data_in = d[i];
         repeat (P) @(negedge clk);
      end
      bus.serial_data_in = (^d) ^ flip_par;
      repeat (P) @(negedge clk);
      bus.serial_data_in = stop;
      repeat (P) @(negedge clk);
      bus.serial_data_in = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] d);
      send_frame(d, 1'b0, 1'b1);
   endtask

   // Reference ALU written from the arithmetic definition of each function.
   function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] f);
      int ai, bi, r;
      ai = a;
      bi = b;
      case (f)
         4'd0:  r = ai + bi;
         4'd1:  r = ai - bi;
         4'd2:  r = ai * bi;
         4'd3:  r = (bi == 0) ? 0 : ai / bi;
         4'd4:  r = ai & bi;
         4'd5:  r = ai | bi;
         4'd6:  r = 255 - (ai & bi);
         4'd7:  r = 255 - (ai | bi);
         4'd8:  r = ai ^ bi;
         4'd9:  r = 255 - (ai ^ bi);
         4'd10: r = (ai == bi) ? 1 : 0;
         4'd11: r = (ai > bi) ? 2 : 0;
         4'd12: r = (ai < bi) ? 3 : 0;
         4'd13: r = ai / 2;
         4'd14: r = ai * 2;
         default: r = 0;
      endcase
      return r[15:0];
   endfunction

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      send_byte(8'hAA); send_byte(a); send_byte(d);
      mreg[a[3:0]] = d;
   endtask

   task automatic do_read(input logic [7:0] a);
      send_byte(8'hBB); send_byte(a);
      exp_q.push_back(mreg[a[3:0]]);
   endtask

   task automatic push_result(input logic [7:0] f);
      logic [15:0] r;
      r = alu_ref(mreg[0], mreg[1], f[3:0]);
      exp_q.push_back(r[7:0]);
      exp_q.push_back(r[15:8]);
   endtask

   task automatic do_alu(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
      send_byte(8'hCC); send_byte(a); send_byte(b); send_byte(f);
      mreg[0] = a;
      mreg[1] = b;
      push_result(f);
   endtask

   task automatic do_nop(input logic [7:0] f);
      send_byte(8'hDD); send_byte(f);
      push_result(f);
   endtask

   // Waits for the expected frames (bounded), lets the line settle so a
   // spurious extra frame would show, then compares and clears.
   task automatic check_resp(input string tag);
      int n;
      int waited;
      n = exp_q.size();
      waited = 0;
      while (mon_byte.size() < n && waited < 40 * 11 * P) begin
         @(negedge clk);
         waited++;
      end
      repeat (14 * P) @(negedge clk);
      check({tag, " frames"}, mon_byte.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < mon_byte.size()) begin
            check($sformatf("%s data%0d", tag, i), mon_byte[i], exp_q[i]);
            check($sformatf("%s par%0d", tag, i), mon_par[i], ^exp_q[i]);
            check($sformatf("%s stop%0d", tag, i), mon_stop[i], 1);
         end
      end
      if (n == 2 && mon_t.size() >= 2)
         check({tag, " gap"}, mon_t[1] - mon_t[0], 12 * P);
      exp_q.delete();
      mon_byte.delete();
      mon_par.delete();
      mon_stop.delete();
      mon_t.delete();
   endtask

   int pe0, fe0, w;
   int kind;

   initial begin
      bus.serial_data_in = 1'b1;
      for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
      repeat (4) @(negedge clk);
      check("reset sdo", bus.serial_data_out, 1);
      check("reset pe", bus.parity_error, 0);
      check("reset fe", bus.frame_error, 0);
      rst = 1'b0;
      repeat (3 * P) @(negedge clk);

      // write then read back
      do_write(8'h05, 8'h3C);
      check_resp("write");
      do_read(8'h05);
      check_resp("read5");

      // ALU with operands, then operands left in reg0/reg1
      do_alu(8'h0F, 8'h03, 8'h00);
      check_resp("add");
      do_read(8'h00);
      check_resp("reg0");
      do_read(8'h01);
      check_resp("reg1");

      // ALU on stored operands
      do_nop(8'h02);
      check_resp("mul");
      do_write(8'h00, 8'hFF);
      do_write(8'h01, 8'hFF);
      do_nop(8'h02);
      check_resp("mulff");

      // edge functions
      do_alu(8'h07, 8'h00, 8'h03);
      check_resp("div0");
      do_alu(8'h03, 8'h07, 8'h01);
      check_resp("subwrap");
      do_alu(8'h09, 8'h09, 8'h0A);
      check_resp("eq");

      // parity error
      pe0 = pe_cnt; fe0 = fe_cnt;
      send_frame(8'h55, 1'b1, 1'b1);
      repeat (2 * P) @(negedge clk);
      check("parerr pe", pe_cnt - pe0, 1);
      check("parerr fe", fe_cnt - fe0, 0);

      // stop-bit error
      pe0 = pe_cnt; fe0 = fe_cnt;
      send_frame(8'h33, 1'b0, 1'b0);
      repeat (2 * P) @(negedge clk);
      check("stoperr fe", fe_cnt - fe0, 1);
      check("stoperr pe", pe_cnt - pe0, 0);

      // both at once
      pe0 = pe_cnt; fe0 = fe_cnt;
      send_frame(8'h01, 1'b1, 1'b0);
      repeat (2 * P) @(negedge clk);
      check("botherr pe", pe_cnt - pe0, 1);
      check("botherr fe", fe_cnt - fe0, 1);
      check_resp("errs");

      // a bad frame inside a command is not consumed
      send_byte(8'hBB);
      send_frame(8'h07, 1'b1, 1'b1);
      send_byte(8'h05);
      exp_q.push_back(mreg[5]);
      check_resp("badmid");

      // unknown command
      send_byte(8'h12);
      check_resp("unknown");

      // two-cycle low glitch
      pe0 = pe_cnt; fe0 = fe_cnt;
      bus.serial_data_in = 1'b0;
      repeat (2) @(negedge clk);
      bus.serial_data_in = 1'b1;
      repeat (4 * P) @(negedge clk);
      check("glitch pe", pe_cnt - pe0, 0);
      check("glitch fe", fe_cnt - fe0, 0);
      check_resp("glitch");
      do_read(8'h05);
      check_resp("afterglitch");

      // a command arriving during a response is dropped
      do_alu(8'h20, 8'h05, 8'h0C);
      send_byte(8'hBB);
      check_resp("busyin");
      send_byte(8'h05);
      check_resp("busyin2");

      // randomized mix
      for (int it = 0; it < 24; it++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0: begin
               do_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
               do_read(8'($urandom_range(0, 255)));
            end
            1: do_read(8'($urandom_range(0, 255)));
            2: begin
               if ($urandom_range(0, 3) == 0) begin
                  w = $urandom_range(0, 255);
                  do_alu(8'(w), 8'(w), 8'($urandom_range(0, 255)));
               end else begin
                  do_alu(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                         8'($urandom_range(0, 255)));
               end
            end
            default: do_nop(8'($urandom_range(0, 255)));
         endcase
         check_resp($sformatf("rand%0d", it));
      end

      // reset in the middle of a response
      do_write(8'h05, 8'hA5);
      send_byte(8'hBB);
      send_byte(8'h05);
      w = 0;
      while (bus.serial_data_out !== 1'b0 && w < 20 * P) begin
         @(negedge clk);
         w++;
      end
      check("midrst started", (w < 20 * P) ? 1 : 0, 1);
      repeat (3 * P) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst sdo", bus.serial_data_out, 1);
      repeat (3) @(negedge clk);
      check("midrst pe", bus.parity_error, 0);
      check("midrst fe", bus.frame_error, 0);
      rst = 1'b0;
      repeat (12 * P) @(negedge clk);
      exp_q.delete();
      mon_byte.delete();
      mon_par.delete();
      mon_stop.delete();
      mon_t.delete();
      for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
      do_read(8'h05);
      check_resp("postrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_cmd_system_top.md
Name: uart_cmd_system_top

Overview:
- Single-clock UART-controlled register-file/ALU subsystem.
- A UART receiver decodes command frames from serial_data_in, and a command controller executes register writes, register reads, and ALU operations.
- Results go back out as UART frames on serial_data_out.
- Top level of the UART command path; it contains the receiver, transmitter, controller, 16x8 register file and 16-bit-result ALU.

Parameters:
- DATA_WIDTH, 8, UART payload and register width.
- REGISTER_FILE_DEPTH, 16, number of registers; address uses the low log2(depth) bits of the address byte.
- PRESCALE, 8, clock cycles per UART bit (even, >=4).

Ports:
- reference_clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- serial_data_in  input  1  UART RX line, idle high.
- serial_data_out  output  1  UART TX line, idle high.
- parity_error  output  1  one-cycle pulse when a received frame fails the parity check.
- frame_error  output  1  one-cycle pulse when a received frame's stop bit is 0.

Behaviour:
- Frame format (11 bits, each held PRESCALE cycles): start 0, data bits LSB first, even parity (data plus parity has an even count of ones), stop 1.
- RX start detection: in IDLE, a 1->0 transition starts a frame.
- RX sampling: the start bit is re-checked at mid-bit by majority vote of the samples at cycles PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1. If the vote is 1, it is a glitch and RX returns to IDLE. Every later bit uses the same mid-bit majority vote.
- RX completion: at the stop-bit vote, the frame is valid only if parity matches and the stop bit is 1. A valid frame produces a one-cycle rx_valid with the byte.
- RX errors: a parity or stop failure pulses the corresponding flag for 1 cycle, and the byte is discarded. Both flags may pulse together.
- RX then returns to IDLE, so back-to-back frames with zero gap are accepted.
- Controller states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUNC, NOP_FUNC, EXEC, TX_LO, TX_HI, TX_RD.
- IDLE command decode:
  - 0xAA -> WR_ADDR.
  - 0xBB -> RD_ADDR.
  - 0xCC -> ALU_A.
  - 0xDD -> NOP_FUNC.
  - Any other byte is ignored and the controller stays in IDLE.
- 0xAA (write): address byte, then data byte; reg[addr] <= data on the data byte's rx_valid. No response.
- 0xBB (read): address byte; reg[addr] is sent as one TX frame (TX_RD).
- 0xCC (ALU with operands): byte A is written to reg0, byte B to reg1, then the function byte.
- 0xDD (ALU without operands): function byte only; uses the current reg0/reg1.
- ALU result: 16 bits, computed in EXEC (1 cycle), then sent as two frames, low byte first (TX_LO then TX_HI).
- ALU functions (func[3:0]; upper bits ignored), A=reg0, B=reg1:
  - 0 A+B; 1 A-B (16-bit two's complement wrap); 2 A*B; 3 A/B (B=0 gives 0).
  - 4 AND; 5 OR; 6 NAND; 7 NOR; 8 XOR; 9 XNOR (logic results zero-extended to 16 bits).
  - 10 gives 1 if A==B else 0; 11 gives 2 if A>B else 0; 12 gives 3 if A<B else 0.
  - 13 A>>1; 14 A<<1 (9-bit result kept); 15 gives 0.
- Framing errors in a command: a discarded frame is simply not consumed; the controller keeps waiting in its current state. No timeout.
- TX start latency: the start bit begins 2 cycles after the rx_valid of the last byte of a command.
- TX busy: the internal transmitter_busy is high from the first start-bit cycle through the last stop-bit cycle.
- Two-frame responses: serial_data_out is held high with busy low for exactly PRESCALE cycles between the two frames.
- Input during responses: bytes received while a response is transmitting are ignored. The controller returns to IDLE after the final stop bit.
- Reset: all registers are cleared to 0 (reg0=reg1=0), the controller and TX/RX return to IDLE, serial_data_out=1, and both error flags are 0. Reset mid-frame aborts the frame with no output pulse.

Test Plan:
- Write/read: send AA,05,3C then BB,05 -> one TX frame with data 0x3C, even parity 0, stop 1.
- ALU with operands, add: send CC,0F,03,00 -> frames 0x12 then 0x00; reg0=0x0F, reg1=0x03 afterwards.
- ALU without operands, multiply: after the previous case, send DD,02 -> 0x2D then 0x00. Then AA,00,FF; AA,01,FF; DD,02 -> 0x01 then 0xFE.
- Edge functions: CC,07,00,03 -> 0x00,0x00 (divide by zero). CC,03,07,01 -> 0xFC,0xFF (subtraction wraps). CC,09,09,0A -> 0x01,0x00 (equal).
- Error handling:
  - A frame with wrong parity pulses parity_error for 1 cycle.
  - A frame with stop=0 pulses frame_error.
  - Neither erroneous frame advances the controller: BB, then a bad frame, then 05 still reads reg5.
- Robustness:
  - Unknown command 0x12 gives no response.
  - A 2-cycle low glitch on serial_data_in is ignored.
  - Reset asserted mid-response forces serial_data_out high immediately, and a subsequent read of reg5 returns 0x00.
